// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath signal bundle for the multicycle MIPS controller
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PcWrite;
    logic       PcWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IrWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] PcSource;
    logic [2:0] AluOp;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, PcSource,
               AluOp, state, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, PcSource,
               AluOp, state, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing the multicycle MIPS datapath
module multicycle_control #(
    parameter int MEM_HANDSHAKE = 1
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);
    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_AND   = 3'b010;
    localparam logic [2:0] ALU_OP_OR    = 3'b011;
    localparam logic [2:0] ALU_OP_FUNCT = 3'b111;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_IMM_EXEC  = 4'd10;
    localparam logic [3:0] S_IMM_WB    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       ready;
    logic       known_op;

    // Without the handshake every memory access is assumed to finish in one cycle.
    assign ready = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.mem_ready;

    always_comb begin
        known_op = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI: known_op = 1'b1;
            default: known_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                 state_d = S_EXECUTE;
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EXEC;
                    default:                  state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
                else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
                else                          state_d = S_FETCH;
            end
            S_MEM_READ:  if (ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (ready) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Outputs are forced to their idle values for as long as rst is held.
    always_comb begin
        bus.PcWrite     = 1'b0;
        bus.PcWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IrWrite     = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.AluSrcA     = 1'b0;
        bus.AluSrcB     = 2'd0;
        bus.PcSource    = 2'd0;
        bus.AluOp       = ALU_OP_ADD;
        bus.state       = 4'd0;
        bus.illegal     = 1'b0;
        if (!rst) begin
            bus.state = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.AluSrcB = 2'd1;
                    bus.IrWrite = ready;
                    bus.PcWrite = ready;
                end
                S_DECODE: begin
                    bus.AluSrcB = 2'd3;
                    bus.illegal = ~known_op;
                end
                S_MEM_ADDR: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'd2;
                end
                S_MEM_READ: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemToReg = 1'b1;
                end
                S_MEM_WRITE: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluOp   = ALU_OP_FUNCT;
                end
                S_ALU_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    bus.AluSrcA     = 1'b1;
                    bus.AluOp       = ALU_OP_SUB;
                    bus.PcWriteCond = 1'b1;
                    bus.PcSource    = 2'd1;
                end
                S_JUMP: begin
                    bus.PcWrite  = 1'b1;
                    bus.PcSource = 2'd2;
                end
                S_IMM_EXEC: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'd2;
                    if (bus.opcode == OP_ANDI)     bus.AluOp = ALU_OP_AND;
                    else if (bus.opcode == OP_ORI) bus.AluOp = ALU_OP_OR;
                    else                           bus.AluOp = ALU_OP_ADD;
                end
                S_IMM_WB: begin
                    bus.RegWrite = 1'b1;
                end
                default: begin
                    bus.state = state_q;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven check of the multicycle controller
module tb_multicycle_control;
    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_FN  = 3'b111;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] BAD  = 6'b111111;

    // f = {PcWrite,PcWriteCond,IorD,MemRead,MemWrite,IrWrite,MemToReg,RegDst,RegWrite,AluSrcA}
    typedef struct packed {
        logic [9:0] f;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aop;
        logic       ill;
        logic [3:0] st;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        ctrl_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if bus_a();
    multicycle_control_if bus_b();

    multicycle_control #(.MEM_HANDSHAKE(1)) dut (.clk(clk), .rst(rst), .bus(bus_a));
    multicycle_control #(.MEM_HANDSHAKE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus_b));

    ctrl_t act_a, act_b;
    assign act_a = {bus_a.PcWrite, bus_a.PcWriteCond, bus_a.IorD, bus_a.MemRead, bus_a.MemWrite,
                    bus_a.IrWrite, bus_a.MemToReg, bus_a.RegDst, bus_a.RegWrite, bus_a.AluSrcA,
                    bus_a.AluSrcB, bus_a.PcSource, bus_a.AluOp, bus_a.illegal, bus_a.state};
    assign act_b = {bus_b.PcWrite, bus_b.PcWriteCond, bus_b.IorD, bus_b.MemRead, bus_b.MemWrite,
                    bus_b.IrWrite, bus_b.MemToReg, bus_b.RegDst, bus_b.RegWrite, bus_b.AluSrcA,
                    bus_b.AluSrcB, bus_b.PcSource, bus_b.AluOp, bus_b.illegal, bus_b.state};

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    function automatic ctrl_t c(input logic [3:0] st, input logic [9:0] f, input logic [1:0] srcb,
                                input logic [1:0] pcsrc, input logic [2:0] aop, input logic ill);
        ctrl_t r;
        r.f = f; r.srcb = srcb; r.pcsrc = pcsrc; r.aop = aop; r.ill = ill; r.st = st;
        return r;
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic rdy, input ctrl_t e);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input ctrl_t got, input ctrl_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    task automatic check_excl(input string name, input ctrl_t got);
        n_cmp++;
        if ((got.f[6] && got.f[5]) || (got.f[5] && got.f[1])) begin
            n_bad++;
            $display("FAIL %s exclusivity: got %b required no MemRead/MemWrite or RegWrite/MemWrite overlap",
                     name, got.f);
        end
    endtask

    ctrl_t E_RST, E_FETCH_R, E_FETCH_W, E_DEC, E_DEC_ILL, E_MADDR, E_MREAD, E_MWB, E_MWRITE;
    ctrl_t E_EXEC, E_ALUWB, E_BRANCH, E_JUMP, E_IMM_ADD, E_IMM_AND, E_IMM_OR, E_IMMWB;

    initial begin
        E_RST     = '0;
        E_FETCH_R = c(4'd0,  10'b1001010000, 2'd1, 2'd0, A_ADD, 1'b0);
        E_FETCH_W = c(4'd0,  10'b0001000000, 2'd1, 2'd0, A_ADD, 1'b0);
        E_DEC     = c(4'd1,  10'b0000000000, 2'd3, 2'd0, A_ADD, 1'b0);
        E_DEC_ILL = c(4'd1,  10'b0000000000, 2'd3, 2'd0, A_ADD, 1'b1);
        E_MADDR   = c(4'd2,  10'b0000000001, 2'd2, 2'd0, A_ADD, 1'b0);
        E_MREAD   = c(4'd3,  10'b0011000000, 2'd0, 2'd0, A_ADD, 1'b0);
        E_MWB     = c(4'd4,  10'b0000001010, 2'd0, 2'd0, A_ADD, 1'b0);
        E_MWRITE  = c(4'd5,  10'b0010100000, 2'd0, 2'd0, A_ADD, 1'b0);
        E_EXEC    = c(4'd6,  10'b0000000001, 2'd0, 2'd0, A_FN,  1'b0);
        E_ALUWB   = c(4'd7,  10'b0000000110, 2'd0, 2'd0, A_ADD, 1'b0);
        E_BRANCH  = c(4'd8,  10'b0100000001, 2'd0, 2'd1, A_SUB, 1'b0);
        E_JUMP    = c(4'd9,  10'b1000000000, 2'd0, 2'd2, A_ADD, 1'b0);
        E_IMM_ADD = c(4'd10, 10'b0000000001, 2'd2, 2'd0, A_ADD, 1'b0);
        E_IMM_AND = c(4'd10, 10'b0000000001, 2'd2, 2'd0, A_AND, 1'b0);
        E_IMM_OR  = c(4'd10, 10'b0000000001, 2'd2, 2'd0, A_OR,  1'b0);
        E_IMMWB   = c(4'd11, 10'b0000000010, 2'd0, 2'd0, A_ADD, 1'b0);

        // reset, then R-type
        add(1, R, 1, E_RST);  add(1, R, 1, E_RST);
        add(0, R, 1, E_FETCH_R); add(0, R, 1, E_DEC); add(0, R, 1, E_EXEC); add(0, R, 1, E_ALUWB);
        // lw with fetch wait and three wait cycles; opcode scrambled while not sampled
        add(0, LW, 0, E_FETCH_W); add(0, LW, 1, E_FETCH_R); add(0, LW, 1, E_DEC); add(0, LW, 1, E_MADDR);
        add(0, BAD, 0, E_MREAD); add(0, BAD, 0, E_MREAD); add(0, BAD, 0, E_MREAD);
        add(0, BAD, 1, E_MREAD); add(0, BAD, 1, E_MWB);
        // sw with one wait cycle
        add(0, SW, 1, E_FETCH_R); add(0, SW, 1, E_DEC); add(0, SW, 1, E_MADDR);
        add(0, SW, 0, E_MWRITE); add(0, SW, 1, E_MWRITE);
        // beq, j, illegal
        add(0, BEQ, 1, E_FETCH_R); add(0, BEQ, 1, E_DEC); add(0, BEQ, 1, E_BRANCH);
        add(0, J, 1, E_FETCH_R); add(0, J, 1, E_DEC); add(0, J, 1, E_JUMP);
        add(0, BAD, 1, E_FETCH_R); add(0, BAD, 1, E_DEC_ILL);
        // immediates
        add(0, ORI, 1, E_FETCH_R); add(0, ORI, 1, E_DEC); add(0, ORI, 1, E_IMM_OR); add(0, ORI, 1, E_IMMWB);
        add(0, ANDI, 1, E_FETCH_R); add(0, ANDI, 1, E_DEC); add(0, ANDI, 1, E_IMM_AND); add(0, ANDI, 1, E_IMMWB);
        add(0, ADDI, 1, E_FETCH_R); add(0, ADDI, 1, E_DEC); add(0, ADDI, 1, E_IMM_ADD); add(0, ADDI, 1, E_IMMWB);
        // reset in the middle of a memory wait
        add(0, LW, 1, E_FETCH_R); add(0, LW, 1, E_DEC); add(0, LW, 1, E_MADDR); add(0, LW, 0, E_MREAD);
        add(1, LW, 0, E_RST); add(1, LW, 0, E_RST);
        add(0, LW, 0, E_FETCH_W); add(0, LW, 1, E_FETCH_R); add(0, LW, 1, E_DEC);

        rst = 1'b1;
        bus_a.opcode = R; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b1;
        bus_b.opcode = R; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            bus_a.opcode = vecs[i].op;
            bus_a.mem_ready = vecs[i].rdy;
            bus_a.zero = vecs[i].op[0];
            #1;
            check($sformatf("vec%0d", i), act_a, vecs[i].exp);
            check_excl($sformatf("vec%0d", i), act_a);
        end

        // no-handshake instance: every memory state lasts one cycle with mem_ready held low
        begin
            ctrl_t seq[$];
            logic [5:0] ops[$];
            @(negedge clk);
            rst = 1'b1;
            bus_b.mem_ready = 1'b0;
            #1;
            check("nohs_reset", act_b, E_RST);
            seq = '{E_FETCH_R, E_DEC, E_MADDR, E_MREAD, E_MWB,
                    E_FETCH_R, E_DEC, E_MADDR, E_MWRITE, E_FETCH_R};
            ops = '{LW, LW, LW, LW, LW, SW, SW, SW, SW, SW};
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                rst = 1'b0;
                bus_b.opcode = ops[k];
                #1;
                check($sformatf("nohs%0d", k), act_b, seq[k]);
            end
        end

        // bounded wait: lw on the handshake instance must reach MEM_WB once mem_ready returns
        begin
            int cyc;
            bit seen;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            bus_a.opcode = LW;
            seen = 1'b0;
            for (cyc = 0; cyc < 20 && !seen; cyc++) begin
                bus_a.mem_ready = (cyc % 3 == 2);
                #1;
                if (bus_a.state == 4'd4) seen = 1'b1;
                else @(negedge clk);
            end
            n_cmp++;
            if (!seen) begin
                n_bad++;
                $display("FAIL lw_wait_timeout: got state %0d required 4 within 20 cycles", bus_a.state);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = memory states wait for mem_ready, 0 = mem_ready ignored (treated high).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-007 SHALL have outputs PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg, RegDst, RegWrite, AluSrcA, each 1 bit, with standard multicycle MIPS datapath meaning.
REQ-008 SHALL have outputs AluSrcB  output  2  (0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2) and PcSource  output  2  (0=ALU, 1=ALUOut, 2=jump target).
REQ-009 SHALL have output AluOp  output  3, using the ALU_OP_* encodings of the shared definitions header; it drives alu_control.
REQ-010 SHALL have outputs state  output  4  (current state code) and illegal  output  1  (one-cycle pulse on unknown opcode).

Function
REQ-011 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11; codes 12-15 unreachable and SHALL go to FETCH.
REQ-012 FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=1, AluOp=ALU_OP_ADD, PcSource=0; IrWrite=PcWrite=1 only in a cycle with mem_ready=1; remain in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-013 DECODE: AluSrcA=0, AluSrcB=3, AluOp=ALU_OP_ADD; next by opcode: 000000->EXECUTE, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000/001100/001101->IMM_EXEC, any other->FETCH with illegal=1 for that DECODE cycle.
REQ-014 MEM_ADDR: AluSrcA=1, AluSrcB=2, AluOp=ALU_OP_ADD; 100011->MEM_READ, 101011->MEM_WRITE.
REQ-015 MEM_READ: MemRead=1, IorD=1; hold until mem_ready=1, then MEM_WB.
REQ-016 MEM_WB: RegWrite=1, MemToReg=1, RegDst=0; ->FETCH.
REQ-017 MEM_WRITE: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
REQ-018 EXECUTE: AluSrcA=1, AluSrcB=0, AluOp=ALU_OP_FUNCT; ->ALU_WB. ALU_WB: RegWrite=1, RegDst=1, MemToReg=0; ->FETCH.
REQ-019 BRANCH: AluSrcA=1, AluSrcB=0, AluOp=ALU_OP_SUB, PcWriteCond=1, PcSource=1; ->FETCH (PC updated externally iff zero=1).
REQ-020 JUMP: PcWrite=1, PcSource=2; ->FETCH.
REQ-021 IMM_EXEC: AluSrcA=1, AluSrcB=2, AluOp = ALU_OP_ADD (001000), ALU_OP_AND (001100), ALU_OP_OR (001101); ->IMM_WB. IMM_WB: RegWrite=1, RegDst=0, MemToReg=0; ->FETCH.
REQ-022 Every output not listed for a state SHALL be 0 in that state; AluOp SHALL be ALU_OP_ADD when unlisted.
REQ-023 opcode SHALL be sampled only in DECODE, MEM_ADDR, IMM_EXEC; changes elsewhere SHALL have no effect.
REQ-024 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite and MemWrite likewise.
REQ-025 With MEM_HANDSHAKE=0, FETCH/MEM_READ/MEM_WRITE SHALL each last exactly one cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL force state to FETCH, from any state including mid memory wait.
REQ-027 While rst=1, all outputs SHALL be 0 (AluOp=ALU_OP_ADD, state=0, illegal=0).
REQ-028 First cycle after rst deasserts SHALL be FETCH with MemRead=1.

Verification
REQ-029 R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0; AluOp=ALU_OP_FUNCT in state 6; RegWrite=1,RegDst=1 in state 7 only.
REQ-030 lw with wait: opcode=100011, mem_ready low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; RegWrite=1,MemToReg=1 only in state 4.
REQ-031 sw: opcode=101011 -> states 0,1,2,5,0; MemWrite=1 exactly one cycle, RegWrite never 1.
REQ-032 beq and j: opcode=000100 -> 0,1,8,0 with AluOp=ALU_OP_SUB,PcWriteCond=1; opcode=000010 -> 0,1,9,0 with PcWrite=1,PcSource=2.
REQ-033 Illegal and ori: opcode=111111 -> 0,1,0 with illegal=1 in DECODE; opcode=001101 -> 0,1,10,11,0 with AluOp=ALU_OP_OR in 10.
REQ-034 Reset mid-op: assert rst in MEM_READ with mem_ready=0 -> next cycle state=0, all outputs 0; deassert -> FETCH with MemRead=1.
